// File: rtl/modexp_ctrl.sv
// Modular exponentiation controller: MSB-first square-and-multiply over an 8-bit
// exponent, with every reduction delegated to an external 16-bit divider.
module modexp_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  base,
  input  logic [7:0]  exponent,
  input  logic [7:0]  modulus,
  output logic [7:0]  result,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [15:0] div_dividend,
  output logic [15:0] div_divisor,
  output logic        div_start,
  input  logic        div_ready,
  input  logic [15:0] div_remainder,
  output logic [3:0]  state_dbg
);

  // Divider handshake: div_start is a level request. The divider acknowledges by
  // dropping div_ready, and raising div_ready again marks div_remainder valid.
  // div_dividend/div_divisor are stable for as long as div_start is high, and
  // div_start returns low for at least one clock between requests.

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_MUL, S_DIV_REQ, S_WAIT_LO,
    S_WAIT_HI, S_DIV_REL, S_NEXT, S_FIN
  } state_t;

  typedef enum logic [1:0] {T_BASE, T_SQ, T_MUL} target_t;

  state_t        state;
  target_t       target;
  logic [7:0]    g;
  logic [7:0]    x;
  logic [7:0]    p;
  logic [7:0]    g_red;
  logic [7:0]    acc;
  logic [2:0]    bit_idx;
  logic [TW-1:0] tcnt;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      target       <= T_BASE;
      g            <= 8'd0;
      x            <= 8'd0;
      p            <= 8'd0;
      g_red        <= 8'd0;
      acc          <= 8'd0;
      bit_idx      <= 3'd0;
      tcnt         <= '0;
      result       <= 8'd0;
      done         <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      div_dividend <= 16'd0;
      div_divisor  <= 16'd0;
      div_start    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            g       <= base;
            x       <= exponent;
            p       <= modulus;
            acc     <= 8'd1;
            bit_idx <= 3'd7;
            result  <= 8'd0;
            busy    <= 1'b1;
            state   <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (p == 8'd0) begin
            result <= 8'd0;
            err    <= 1'b1;
            done   <= 1'b1;
            state  <= S_FIN;
          end else if (p == 8'd1) begin
            result <= 8'd0;
            err    <= 1'b0;
            done   <= 1'b1;
            state  <= S_FIN;
          end else begin
            // Base may exceed the modulus, so it is reduced once up front.
            div_dividend <= {8'd0, g};
            div_divisor  <= {8'd0, p};
            target       <= T_BASE;
            state        <= S_DIV_REQ;
          end
        end

        S_MUL: begin
          if (target == T_SQ) begin
            div_dividend <= {8'd0, acc} * {8'd0, acc};
          end else begin
            div_dividend <= {8'd0, acc} * {8'd0, g_red};
          end
          state <= S_DIV_REQ;
        end

        S_DIV_REQ: begin
          div_start <= 1'b1;
          tcnt      <= '0;
          state     <= S_WAIT_LO;
        end

        S_WAIT_LO: begin
          if (!div_ready) begin
            tcnt  <= '0;
            state <= S_WAIT_HI;
          end else if (tcnt == TLAST) begin
            div_start <= 1'b0;
            result    <= 8'd0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= S_FIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_WAIT_HI: begin
          if (div_ready) begin
            div_start <= 1'b0;
            // A remainder can never reach 256 for an 8-bit modulus; treat one as a divider fault.
            if (|div_remainder[15:8]) begin
              result <= 8'd0;
              err    <= 1'b1;
              done   <= 1'b1;
              state  <= S_FIN;
            end else begin
              if (target == T_BASE) begin
                g_red <= div_remainder[7:0];
              end else begin
                acc <= div_remainder[7:0];
              end
              state <= S_DIV_REL;
            end
          end else if (tcnt == TLAST) begin
            div_start <= 1'b0;
            result    <= 8'd0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= S_FIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_DIV_REL: begin
          state <= S_NEXT;
        end

        S_NEXT: begin
          if (target == T_BASE) begin
            target <= T_SQ;
            state  <= S_MUL;
          end else if (target == T_SQ && x[bit_idx]) begin
            target <= T_MUL;
            state  <= S_MUL;
          end else if (bit_idx == 3'd0) begin
            result <= acc;
            err    <= 1'b0;
            done   <= 1'b1;
            state  <= S_FIN;
          end else begin
            bit_idx <= bit_idx - 3'd1;
            target  <= T_SQ;
            state   <= S_MUL;
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural 16-cycle divider, arithmetic reference model,
// directed cases, randomized operations, timeout and mid-division reset.
module tb_modexp_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base = 8'd0;
  logic [7:0]  exponent = 8'd0;
  logic [7:0]  modulus = 8'd0;
  logic [7:0]  result;
  logic        done;
  logic        busy;
  logic        err;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_start;
  logic        div_ready = 1'b1;
  logic [15:0] div_remainder = 16'd0;
  logic [3:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  modexp_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .result(result), .done(done), .busy(busy), .err(err),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
    .div_ready(div_ready), .div_remainder(div_remainder), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- divider model (16 iterations) ----------------
  bit          tie_ready = 1'b0;
  int          div_edges = 0;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic        m_prev = 1'b0;
  logic [15:0] m_dvd = 16'd0;
  logic [15:0] m_dvs = 16'd0;

  always @(negedge clk) begin
    if (!rst) begin
      div_ready = 1'b1;
      m_busy    = 1'b0;
      m_prev    = 1'b0;
    end else begin
      if (div_start && !m_prev) begin
        div_edges++;
        if (!tie_ready) begin
          m_busy    = 1'b1;
          m_cnt     = 16;
          div_ready = 1'b0;
          m_dvd     = div_dividend;
          m_dvs     = div_divisor;
        end
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy        = 1'b0;
          div_ready     = 1'b1;
          div_remainder = (m_dvs == 16'd0) ? 16'hffff : (m_dvd % m_dvs);
        end else begin
          div_remainder = 16'($urandom);
        end
      end
      m_prev = div_start;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_modexp(input int g, input int x, input int p);
    int r;
    int b;
    if (p < 2) return 8'd0;
    r = 1;
    b = g % p;
    for (int i = 0; i < x; i++) r = (r * b) % p;
    return 8'(r);
  endfunction

  function automatic int ref_reductions(input int x, input int p);
    if (p < 2) return 0;
    return 9 + $countones(8'(x));
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [7:0] g, input logic [7:0] x, input logic [7:0] p,
                        output logic [7:0] res, output logic e, output int lat,
                        output int edges, output bit timed_out, output logic b_acc,
                        output logic b_done, output logic b_after);
    @(negedge clk);
    base = g; exponent = x; modulus = p; start = 1'b1;
    div_edges = 0;
    @(negedge clk);
    start = 1'b0;
    base = 8'($urandom); exponent = 8'($urandom); modulus = 8'($urandom);
    b_acc = busy;
    lat = 0;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    timed_out = !done;
    res = result;
    e = err;
    b_done = busy;
    edges = div_edges;
    @(negedge clk);
    b_after = busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (result !== 8'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
    checks++; if ({done, busy, err, div_start} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {done, busy, err, div_start}); end
    checks++; if ({div_dividend, div_divisor} !== 32'd0) begin errors++; $display("FAIL reset_div_operands: got %h expected 0", {div_dividend, div_divisor}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] tg[6] = '{8'd3, 8'd2,   8'd9,  8'd200, 8'd45, 8'd77};
    logic [7:0] tx[6] = '{8'd5, 8'd255, 8'd0,  8'd2,   8'd0,  8'd13};
    logic [7:0] tp[6] = '{8'd7, 8'd251, 8'd11, 8'd7,   8'd0,  8'd1};
    logic [7:0] want[6] = '{8'd5, 8'd32, 8'd1, 8'd2, 8'd0, 8'd0};
    int want_edges[6] = '{11, 17, 9, 10, 0, 0};
    logic [7:0] res; logic e; int lat; int edges; bit to; logic ba, bd, bf;
    for (int i = 0; i < 6; i++) begin
      run_op(tg[i], tx[i], tp[i], res, e, lat, edges, to, ba, bd, bf);
      checks++; if (to) begin errors++; $display("FAIL dir%0d_done: no done within 1000 clocks", i); end
      checks++; if (res !== want[i]) begin errors++; $display("FAIL dir%0d_result: got %0d expected %0d", i, res, want[i]); end
      checks++; if (e !== (tp[i] == 8'd0)) begin errors++; $display("FAIL dir%0d_err: got %b expected %b", i, e, tp[i] == 8'd0); end
      checks++; if (edges != want_edges[i]) begin errors++; $display("FAIL dir%0d_div_edges: got %0d expected %0d", i, edges, want_edges[i]); end
      checks++; if ({ba, bd, bf} !== 3'b110) begin errors++; $display("FAIL dir%0d_busy: got %b expected 110", i, {ba, bd, bf}); end
      checks++; if (lat > 400) begin errors++; $display("FAIL dir%0d_latency: got %0d expected <=400", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [7:0] g, x, p, res, want; logic e; int lat; int edges; bit to; logic ba, bd, bf;
    for (int i = 0; i < 24; i++) begin
      g = 8'($urandom);
      x = 8'($urandom);
      p = (i % 8 == 7) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 255));
      exp_q.push_back(ref_modexp(g, x, p));
      run_op(g, x, p, res, e, lat, edges, to, ba, bd, bf);
      want = exp_q.pop_front();
      checks++; if (to || res !== want) begin errors++; $display("FAIL rand%0d_result g=%0d x=%0d p=%0d: got %0d expected %0d", i, g, x, p, res, want); end
      checks++; if (e !== (p == 8'd0)) begin errors++; $display("FAIL rand%0d_err: got %b expected %b", i, e, p == 8'd0); end
      checks++; if (edges != ref_reductions(x, p)) begin errors++; $display("FAIL rand%0d_div_edges: got %0d expected %0d", i, edges, ref_reductions(x, p)); end
    end
  endtask

  task automatic test_start_ignored();
    int n = 0;
    @(negedge clk);
    base = 8'd3; exponent = 8'd5; modulus = 8'd7; start = 1'b1;
    @(negedge clk);
    while (!done && n < 1000) begin
      start = 1'($urandom_range(0, 1));
      base = 8'($urandom); exponent = 8'($urandom); modulus = 8'($urandom);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++; if (!done || result !== 8'd5) begin errors++; $display("FAIL start_ignored_result: got %0d expected 5", result); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_ignored_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    int n = 0;
    tie_ready = 1'b1;
    @(negedge clk);
    base = 8'd3; exponent = 8'd5; modulus = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!div_start && n < 100) begin @(negedge clk); n++; end
    checks++; if (!div_start) begin errors++; $display("FAIL timeout_request: div_start got 0 expected 1"); end
    n = 0;
    while (!done && n < 3 * TO) begin @(negedge clk); n++; end
    checks++; if (n != TO) begin errors++; $display("FAIL timeout_latency: got %0d clocks expected %0d", n, TO); end
    checks++; if ({done, err, div_start} !== 3'b110) begin errors++; $display("FAIL timeout_flags: done/err/div_start got %b expected 110", {done, err, div_start}); end
    checks++; if (result !== 8'd0) begin errors++; $display("FAIL timeout_result: got %0d expected 0", result); end
    tie_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [7:0] res; logic e; int lat; int edges; bit to; logic ba, bd, bf;
    @(negedge clk);
    base = 8'd3; exponent = 8'd5; modulus = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(m_busy && m_cnt == 8) && n < 200) begin @(negedge clk); n++; end
    checks++; if (!(div_start && !div_ready)) begin errors++; $display("FAIL rstmid_in_wait: start/ready got %b%b expected 10", div_start, div_ready); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({done, busy, err, div_start} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b expected 0000", {done, busy, err, div_start}); end
    checks++; if ({result, div_dividend, div_divisor} !== 40'd0) begin errors++; $display("FAIL rstmid_values: got %h expected 0", {result, div_dividend, div_divisor}); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    run_op(8'd3, 8'd5, 8'd7, res, e, lat, edges, to, ba, bd, bf);
    checks++; if (to || res !== 8'd5 || e !== 1'b0) begin errors++; $display("FAIL rstmid_rerun: result/err got %0d/%b expected 5/0", res, e); end
    checks++; if (edges != 11) begin errors++; $display("FAIL rstmid_div_edges: got %0d expected 11", edges); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
